// File: rtl/frame_parser.sv
// Frame parser for the 64-bit test-frame stream feeding the DDR-write side.
// It hunts for a header and checks the sync field and the trailer. It
// extracts cmd/len/arg, XORs the payload, and presents each good frame in a
// single output slot.
//
// Handshake: frm_valid stays high and every frm_* field stays stable until
// a cycle with frm_valid && frm_ready, which consumes the slot. The input
// side has no backpressure: a word moves whenever in_valid is high.
module frame_parser #(
  parameter logic [63:0] HEADER    = 64'hFF00_5A5A_55AA_0F0F,
  parameter logic [15:0] SYNC      = 16'hBCBC,
  parameter logic [15:0] TRAILER   = 16'hFCFC,
  parameter int unsigned MAX_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [63:0] in_data,
  output logic        frm_valid,
  input  logic        frm_ready,
  output logic [15:0] frm_cmd,
  output logic [15:0] frm_len,
  output logic [15:0] frm_arg,
  output logic [47:0] frm_tail,
  output logic [7:0]  frm_nwords,
  output logic [63:0] frm_xor,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt,
  output logic [2:0]  err_code
);

  typedef enum logic [1:0] {IDLE, HDR2, BODY, DROP} state_t;

  localparam logic [7:0] MAX_W8 = 8'(MAX_WORDS);

  localparam logic [2:0] E_HDR   = 3'd1;
  localparam logic [2:0] E_SHORT = 3'd2;
  localparam logic [2:0] E_SYNC  = 3'd3;
  localparam logic [2:0] E_SIZE  = 3'd4;
  localparam logic [2:0] E_TRAIL = 3'd5;
  localparam logic [2:0] E_OVF   = 3'd6;

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  pend;
  logic [15:0] cmd_q;
  logic [15:0] len_q;
  logic [15:0] arg_q;
  logic [63:0] xor_acc;

  logic        done;
  logic        err_ev;
  logic [2:0]  err_val;
  logic        ovf;

  // Decode the events produced by the current accepted word: a completed frame or a logged error
  always_comb begin
    done    = 1'b0;
    err_ev  = 1'b0;
    err_val = 3'd0;
    if (in_valid && in_last) begin
      case (state)
        IDLE: begin
          err_ev  = 1'b1;
          err_val = (in_data == HEADER) ? E_SHORT : E_HDR;
        end
        HDR2: begin
          err_ev  = 1'b1;
          err_val = E_SHORT;
        end
        BODY: begin
          if (in_data[15:0] != TRAILER) begin
            err_ev  = 1'b1;
            err_val = E_TRAIL;
          end else begin
            done = 1'b1;
          end
        end
        DROP: begin
          err_ev  = 1'b1;
          err_val = pend;
        end
        default: ;
      endcase
    end
  end

  // A completed frame that finds the slot occupied and not being consumed is lost
  assign ovf = done && frm_valid && !frm_ready;

  // Frame hunting FSM and per-frame accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      pend    <= 3'd0;
      cmd_q   <= 16'd0;
      len_q   <= 16'd0;
      arg_q   <= 16'd0;
      xor_acc <= 64'd0;
    end else if (in_valid) begin
      case (state)
        IDLE: begin
          if (!in_last) begin
            if (in_data == HEADER) begin
              state <= HDR2;
              cnt   <= 8'd1;
            end else begin
              state <= DROP;
              pend  <= E_HDR;
            end
          end
        end
        HDR2: begin
          if (in_last) begin
            state <= IDLE;
          end else if (in_data[63:48] != SYNC) begin
            state <= DROP;
            pend  <= E_SYNC;
          end else begin
            cmd_q   <= in_data[47:32];
            len_q   <= in_data[31:16];
            arg_q   <= in_data[15:0];
            cnt     <= 8'd2;
            xor_acc <= 64'd0;
            state   <= BODY;
          end
        end
        BODY: begin
          if (in_last) begin
            state <= IDLE;
          end else if (cnt + 8'd1 == MAX_W8) begin
            state <= DROP;
            pend  <= E_SIZE;
          end else begin
            xor_acc <= xor_acc ^ in_data;
            cnt     <= cnt + 8'd1;
          end
        end
        DROP: begin
          if (in_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output slot, good/error counters and sticky error code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_valid  <= 1'b0;
      frm_cmd    <= 16'd0;
      frm_len    <= 16'd0;
      frm_arg    <= 16'd0;
      frm_tail   <= 48'd0;
      frm_nwords <= 8'd0;
      frm_xor    <= 64'd0;
      good_cnt   <= 16'd0;
      err_cnt    <= 16'd0;
      err_code   <= 3'd0;
    end else begin
      if (done && (!frm_valid || frm_ready)) begin
        frm_valid  <= 1'b1;
        frm_cmd    <= cmd_q;
        frm_len    <= len_q;
        frm_arg    <= arg_q;
        frm_tail   <= in_data[63:16];
        frm_nwords <= cnt + 8'd1;
        frm_xor    <= xor_acc;
        if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
      end else if (frm_valid && frm_ready) begin
        frm_valid <= 1'b0;
      end
      if (err_ev || ovf) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        err_code <= ovf ? E_OVF : err_val;
      end
    end
  end

endmodule
